dp_controller: RTL and testbench
================================

// Module: dp_controller
// PURPOSE
//  Control unit for the single-cycle datapath DP: decodes instOut (opcode, ins[15:12]) and funcOut (ins[7:0])
//  into DP mux selects, ALU function and write strobes. Adds a run-control FSM (boot, run, single-step,
//  halt, fault) that gates every state-changing DP strobe, plus a retired-instruction counter.
// PARAMETERS
//  BOOT_CYCLES  2   cycles rstPC held after rst deasserts (>=1)
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      synchronous, active-high; also drives DP rst externally
//  instOut    in   4      opcode from DP
//  funcOut    in   8      ins[7:0] from DP (one-hot func for R-type, window id for WIN)
//  step_mode  in   1      1 = single-step; commit only on cycles with step_req
//  step_req   in   1      step pulse; ignored unless step_mode=1 and state RUN
//  go         in   1      resume from HALT
//  rstPC,ldPC,pcSel,branchSel,jumpSel,regSel,inSel,selDm,selALU,regWrite,nop,ldWnd,memWrite,memRead  out 1 each
//  wndCtrl    out  2      new window for WIN (funcOut[1:0])
//  funcCtrl   out  3      ALU function
//  halted     out  1      state==HALT
//  fault      out  1      state==FAULT (sticky until rst)
//  retired    out  CNT_W  committed-instruction count, wraps
// BEHAVIOUR
//  Opcodes: 0000 LDM (selDm,memRead,regWrite); 0001 STM (memWrite); 0010 JMP (jumpSel); 0100 BZ
//   (branchSel, funcCtrl=SUB); 1000 RTYPE (regSel,selALU,regWrite, func from funcOut); 1001 WIN (ldWnd);
//   0111 HALT; 1100/1101/1110/1111 ADDI/SUBI/ANDI/ORI (inSel,selALU,regWrite). All others illegal.
//  RTYPE funcOut one-hot: [0]MOV [1]ADD [2]SUB [3]AND [4]OR [5]NOT [6]NOP; [7], zero or multi-hot -> illegal.
//  ALU codes: PASSB 000, ADD 001, SUB 010, AND 011, OR 100, NOTB 101.
//  pcSel=1 for every non-JMP decode; DP PC mux priority is jumpSel > branch-taken > pcSel.
//  nop is active-low write enable into DP (DP writes iff regWrite&nop); nop=0 for RTYPE-NOP and every
//   non-committing cycle.
//  Decode outputs (selects, funcCtrl, wndCtrl) are combinational from instOut/funcOut in all states.
//  commit = (state==RUN) & (~step_mode | step_req) & legal & ~rst. ldPC, regWrite, memWrite, memRead,
//   ldWnd are ANDed with commit; otherwise 0.
//  FSM: BOOT -> RUN after BOOT_CYCLES cycles; RUN -> HALT on committed HALT (ldPC=1, PC moves past it);
//   RUN -> FAULT on illegal opcode/func when commit would otherwise fire (ldPC=0, PC stays on bad
//   instruction); HALT -> RUN when go=1 (no commit that cycle); FAULT exits only via rst.
//  rstPC = rst | (state==BOOT). In BOOT/HALT/FAULT/rst all strobes 0.
//  Reset (incl. mid-instruction or in any state): state=BOOT, boot counter=0, retired=0, halted=0, fault=0;
//   a commit coinciding with rst is suppressed.
//  retired += 1 on each commit (incl. HALT, RTYPE-NOP, not-taken BZ); wraps 2^CNT_W-1 -> 0.
//  step_mode toggled mid-run takes effect the same cycle; step_req held high commits once per cycle.
//  Latency: decode 0 cycles; state/counter updates visible next edge.
// STRUCTURE
//  cpu_pkg: opcode constants, RTYPE func bit indices, ALU codes, FSM state enum (BOOT,RUN,HALT,FAULT).
//  Sub-module inst_decoder (combinational): instOut/funcOut -> raw selects, funcCtrl, wndCtrl, is_halt,
//   illegal. dp_controller holds FSM, boot counter, retire counter and commit gating.
// TESTING
//  rst 1 cycle, BOOT_CYCLES=2 -> rstPC=1 for rst cycle + 2 more, ldPC=0 until RUN, retired=0.
//  RUN, instOut=1000, funcOut=8'h02 -> funcCtrl=001, regSel=1, selALU=1, regWrite=1, nop=1, ldPC=1, retired+1.
//  instOut=0111 -> ldPC=1 that cycle, halted=1 next; no strobes while halted; go=1 -> RUN next cycle.
//  instOut=0011 (or RTYPE funcOut=8'h03) -> ldPC=0, regWrite=0, fault=1 next; persists until rst.
//  step_mode=1, step_req low 5 cycles then one pulse -> exactly one ldPC/regWrite pulse, retired+1.
//  retired preloaded to 16'hFFFF by 65535 commits, one more commit -> 16'h0000; rst while in HALT -> BOOT.

Source files
------------

// File: rtl/dp_controller_pkg.sv
// Shared definitions for the DP control unit: opcodes, ALU codes, run-control states
// and the decoded-instruction bundle passed from the decoder to the run-control logic.
package dp_controller_pkg;

  localparam logic [3:0] OP_LDM   = 4'b0000;
  localparam logic [3:0] OP_STM   = 4'b0001;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_BZ    = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0111;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_WIN   = 4'b1001;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  // RTYPE one-hot function bit positions within funcOut
  localparam int F_MOV = 0;
  localparam int F_ADD = 1;
  localparam int F_SUB = 2;
  localparam int F_AND = 3;
  localparam int F_OR  = 4;
  localparam int F_NOT = 5;
  localparam int F_NOP = 6;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_NOTB  = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic       jump_sel;
    logic       branch_sel;
    logic       reg_sel;
    logic       in_sel;
    logic       sel_dm;
    logic       sel_alu;
    logic       reg_write;
    logic       ld_wnd;
    logic       mem_write;
    logic       mem_read;
    logic       is_halt;
    logic       is_nop;
    logic       illegal;
    alu_op_e    func;
    logic [1:0] wnd;
  } dec_t;

endpackage

// File: rtl/dp_controller_if.sv
// Control bus between the controller and the datapath: instruction fields in,
// mux selects / ALU function / write strobes out.
interface dp_controller_if;
  logic [3:0] instOut;
  logic [7:0] funcOut;
  logic       rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel;
  logic       selDm, selALU, regWrite, nop, ldWnd, memWrite, memRead;
  logic [1:0] wndCtrl;
  logic [2:0] funcCtrl;

  modport master (
    input  instOut, funcOut,
    output rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel,
           selDm, selALU, regWrite, nop, ldWnd, memWrite, memRead,
           wndCtrl, funcCtrl
  );

  modport slave (
    output instOut, funcOut,
    input  rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel,
           selDm, selALU, regWrite, nop, ldWnd, memWrite, memRead,
           wndCtrl, funcCtrl
  );
endinterface

// File: rtl/dp_controller_inst_decoder.sv
// Purely combinational instruction decoder: opcode/func -> raw (ungated) selects,
// ALU function, window id and halt/illegal flags.
module inst_decoder
  import dp_controller_pkg::*;
(
  input  logic [3:0] instOut,
  input  logic [7:0] funcOut,
  output dec_t       dec_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec_o      = '0;
    dec_o.func = ALU_PASSB;
    unique case (instOut)
      OP_LDM:  begin dec_o.sel_dm = 1'b1; dec_o.mem_read = 1'b1; dec_o.reg_write = 1'b1; end
      OP_STM:  dec_o.mem_write = 1'b1;
      OP_JMP:  dec_o.jump_sel  = 1'b1;
      OP_BZ:   begin dec_o.branch_sel = 1'b1; dec_o.func = ALU_SUB; end
      OP_HALT: dec_o.is_halt   = 1'b1;
      OP_WIN:  begin dec_o.ld_wnd = 1'b1; dec_o.wnd = funcOut[1:0]; end
      OP_RTYPE: begin
        dec_o.reg_sel   = 1'b1;
        dec_o.sel_alu   = 1'b1;
        dec_o.reg_write = 1'b1;
        // funcOut must be exactly one of bits [6:0]; bit 7, zero or multi-hot is illegal
        unique case (funcOut)
          8'(1 << F_MOV): dec_o.func = ALU_PASSB;
          8'(1 << F_ADD): dec_o.func = ALU_ADD;
          8'(1 << F_SUB): dec_o.func = ALU_SUB;
          8'(1 << F_AND): dec_o.func = ALU_AND;
          8'(1 << F_OR):  dec_o.func = ALU_OR;
          8'(1 << F_NOT): dec_o.func = ALU_NOTB;
          8'(1 << F_NOP): dec_o.is_nop = 1'b1;
          default:        dec_o.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        dec_o.in_sel    = 1'b1;
        dec_o.sel_alu   = 1'b1;
        dec_o.reg_write = 1'b1;
        unique case (instOut[1:0])
          2'b00:   dec_o.func = ALU_ADD;
          2'b01:   dec_o.func = ALU_SUB;
          2'b10:   dec_o.func = ALU_AND;
          default: dec_o.func = ALU_OR;
        endcase
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dp_controller.sv
// DP control unit top: run-control FSM (boot/run/halt/fault), single-step gating of
// every state-changing strobe, and a wrapping retired-instruction counter.
module dp_controller
  import dp_controller_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  dp_controller_if.master   dp,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              go,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  dec_t             dec;
  state_e           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             slot, commit;

  inst_decoder u_dec (
    .instOut (dp.instOut),
    .funcOut (dp.funcOut),
    .dec_o   (dec)
  );

  // slot: an instruction would retire this cycle if it is legal
  assign slot   = (state_q == ST_RUN) && (!step_mode || step_req) && !rst;
  assign commit = slot && !dec.illegal;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) state_d = ST_RUN;
        else                                     boot_cnt_d = boot_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (slot && dec.illegal)      state_d = ST_FAULT;
        else if (commit && dec.is_halt) state_d = ST_HALT;
      end
      ST_HALT:  if (go) state_d = ST_RUN;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      if (commit) retired_q <= retired_q + 1'b1;
    end
  end

  assign dp.rstPC     = rst || (state_q == ST_BOOT);
  assign dp.ldPC      = commit;
  assign dp.pcSel     = !dec.jump_sel;
  assign dp.branchSel = dec.branch_sel;
  assign dp.jumpSel   = dec.jump_sel;
  assign dp.regSel    = dec.reg_sel;
  assign dp.inSel     = dec.in_sel;
  assign dp.selDm     = dec.sel_dm;
  assign dp.selALU    = dec.sel_alu;
  assign dp.regWrite  = dec.reg_write && commit;
  assign dp.nop       = commit && !dec.is_nop;
  assign dp.ldWnd     = dec.ld_wnd && commit;
  assign dp.memWrite  = dec.mem_write && commit;
  assign dp.memRead   = dec.mem_read && commit;
  assign dp.wndCtrl   = dec.wnd;
  assign dp.funcCtrl  = dec.func;

  assign halted  = (state_q == ST_HALT);
  assign fault   = (state_q == ST_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_dp_controller.sv
// Directed self-checking bench for dp_controller: boot timing, decode, halt/go,
// fault, single-step, reset suppression and retired-counter wrap.
module tb_dp_controller;

  logic        clk = 1'b0;
  logic        rst, step_mode, step_req, go;
  logic        halted, fault;
  logic [15:0] retired;
  int          pass_cnt = 0;
  int          total    = 0;
  int          fail_cnt = 0;

  dp_controller_if bus ();

  dp_controller #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .dp        (bus),
    .step_mode (step_mode),
    .step_req  (step_req),
    .go        (go),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are changed and outputs sampled 2 ns after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_inst(input logic [3:0] op, input logic [7:0] fn);
    bus.instOut = op;
    bus.funcOut = fn;
    #1;
  endtask

  initial begin
    rst = 1'b1; step_mode = 1'b0; step_req = 1'b0; go = 1'b0;
    set_inst(4'b1000, 8'h02);
    tick();
    check("rst_rstPC", bus.rstPC, 1);
    check("rst_ldPC", bus.ldPC, 0);
    check("rst_retired", retired, 0);

    rst = 1'b0; #1;
    check("boot1_rstPC", bus.rstPC, 1);
    check("boot1_ldPC", bus.ldPC, 0);
    tick();
    check("boot2_rstPC", bus.rstPC, 1);
    check("boot2_ldPC", bus.ldPC, 0);
    tick();

    // RUN, RTYPE ADD
    check("run_rstPC", bus.rstPC, 0);
    check("add_func", bus.funcCtrl, 3'b001);
    check("add_regSel", bus.regSel, 1);
    check("add_selALU", bus.selALU, 1);
    check("add_regWrite", bus.regWrite, 1);
    check("add_nop", bus.nop, 1);
    check("add_ldPC", bus.ldPC, 1);
    check("add_pcSel", bus.pcSel, 1);
    check("pre_retired", retired, 0);
    tick();
    check("add_retired", retired, 1);

    set_inst(4'b0000, 8'h00);
    check("ldm_selDm", bus.selDm, 1);
    check("ldm_memRead", bus.memRead, 1);
    check("ldm_regWrite", bus.regWrite, 1);
    tick();
    set_inst(4'b0001, 8'h00);
    check("stm_memWrite", bus.memWrite, 1);
    check("stm_regWrite", bus.regWrite, 0);
    tick();
    set_inst(4'b0010, 8'h00);
    check("jmp_jumpSel", bus.jumpSel, 1);
    check("jmp_pcSel", bus.pcSel, 0);
    tick();
    set_inst(4'b0100, 8'h00);
    check("bz_branchSel", bus.branchSel, 1);
    check("bz_func", bus.funcCtrl, 3'b010);
    tick();
    set_inst(4'b1111, 8'h00);
    check("ori_inSel", bus.inSel, 1);
    check("ori_func", bus.funcCtrl, 3'b100);
    tick();
    set_inst(4'b1101, 8'h00);
    check("subi_func", bus.funcCtrl, 3'b010);
    tick();
    set_inst(4'b1001, 8'h02);
    check("win_ldWnd", bus.ldWnd, 1);
    check("win_wndCtrl", bus.wndCtrl, 2'b10);
    tick();
    set_inst(4'b1000, 8'h20);
    check("not_func", bus.funcCtrl, 3'b101);
    tick();
    set_inst(4'b1000, 8'h40);
    check("rnop_nop", bus.nop, 0);
    check("rnop_ldPC", bus.ldPC, 1);
    tick();
    check("seq_retired", retired, 10);

    // HALT commits, then idles until go
    set_inst(4'b0111, 8'h00);
    check("halt_ldPC", bus.ldPC, 1);
    check("halt_pre", halted, 0);
    tick();
    check("halted", halted, 1);
    check("halt_retired", retired, 11);
    set_inst(4'b1000, 8'h02);
    check("halted_ldPC", bus.ldPC, 0);
    check("halted_regWrite", bus.regWrite, 0);
    check("halted_nop", bus.nop, 0);
    tick();
    go = 1'b1; #1;
    check("go_ldPC", bus.ldPC, 0);
    tick();
    go = 1'b0; #1;
    check("resumed", halted, 0);
    check("resumed_ldPC", bus.ldPC, 1);
    tick();
    check("resume_retired", retired, 12);

    // single step: five idle cycles, one pulse
    step_mode = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check("step_idle_ldPC", bus.ldPC, 0);
      check("step_idle_regWrite", bus.regWrite, 0);
      tick();
    end
    check("step_idle_retired", retired, 12);
    step_req = 1'b1; #1;
    check("step_ldPC", bus.ldPC, 1);
    check("step_regWrite", bus.regWrite, 1);
    tick();
    step_req = 1'b0; #1;
    check("step_after_ldPC", bus.ldPC, 0);
    tick();
    check("step_retired", retired, 13);
    step_mode = 1'b0;

    // illegal RTYPE func -> FAULT, sticky
    set_inst(4'b1000, 8'h03);
    check("badfn_ldPC", bus.ldPC, 0);
    check("badfn_regWrite", bus.regWrite, 0);
    tick();
    check("badfn_fault", fault, 1);
    check("badfn_retired", retired, 13);
    set_inst(4'b1000, 8'h02);
    check("fault_ldPC", bus.ldPC, 0);
    tick();
    check("fault_sticky", fault, 1);

    rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("fault_cleared", fault, 0);
    check("fault_rst_retired", retired, 0);
    tick(); tick();

    // illegal opcode -> FAULT
    set_inst(4'b0011, 8'h00);
    check("badop_ldPC", bus.ldPC, 0);
    tick();
    check("badop_fault", fault, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    set_inst(4'b1000, 8'h02);
    tick(); tick();

    // counter wrap
    check("wrap_start", retired, 0);
    repeat (65535) tick();
    check("wrap_ffff", retired, 16'hFFFF);
    tick();
    check("wrap_zero", retired, 0);
    tick();
    check("wrap_one", retired, 1);

    // commit coinciding with rst is suppressed
    rst = 1'b1; #1;
    check("rst_commit_ldPC", bus.ldPC, 0);
    check("rst_commit_regWrite", bus.regWrite, 0);
    tick();
    check("rst_commit_retired", retired, 0);
    rst = 1'b0;
    tick(); tick();

    // rst while halted -> BOOT
    set_inst(4'b0111, 8'h00);
    tick();
    check("halt2", halted, 1);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_rstPC", bus.rstPC, 1);
    check("halt_rst_retired", retired, 0);
    tick(); tick();
    check("reboot_rstPC", bus.rstPC, 0);
    check("reboot_ldPC", bus.ldPC, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
